// File: rtl/tpu_ctrl_seq.sv
// GEMM command sequencer driving the TPU core ctrl_* inputs: weight load, data stream, bias hold, writeback drain.
// Latency: accept_w/sys_valid trail their UB reads by UB_RD_LAT; one command at a time, cmd_ready only in IDLE.
module tpu_ctrl_seq #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int ADDR_WIDTH           = 10,
    parameter int UB_RD_LAT            = 1,
    parameter int DRAIN_TIMEOUT        = 1024
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]                   cmd_addr_a,
    input  logic [ADDR_WIDTH-1:0]                   cmd_addr_b,
    input  logic [ADDR_WIDTH-1:0]                   cmd_addr_c,
    input  logic [ADDR_WIDTH-1:0]                   cmd_addr_d,
    input  logic [ADDR_WIDTH-1:0]                   cmd_num_rows,
    input  logic [2:0]                              cmd_vpu_mode,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]         cmd_row_mask,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]         cmd_col_mask,
    output logic [ADDR_WIDTH-1:0]                   ctrl_rd_addr_a,
    output logic                                    ctrl_rd_en_a,
    output logic                                    ctrl_accept_w,
    output logic [$clog2(SYSTOLIC_ARRAY_WIDTH)-1:0] ctrl_weight_index,
    output logic [ADDR_WIDTH-1:0]                   ctrl_rd_addr_b,
    output logic                                    ctrl_rd_en_b,
    output logic                                    ctrl_sys_valid,
    output logic                                    ctrl_sys_switch,
    output logic [ADDR_WIDTH-1:0]                   ctrl_rd_addr_c,
    output logic                                    ctrl_rd_en_c,
    output logic [2:0]                              ctrl_vpu_mode,
    output logic [ADDR_WIDTH-1:0]                   ctrl_wr_addr_d,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0]         ctrl_row_mask,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0]         ctrl_col_mask,
    input  logic                                    writeback_done,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    err
);
    localparam int W    = SYSTOLIC_ARRAY_WIDTH;
    localparam int AW   = ADDR_WIDTH;
    localparam int IDXW = $clog2(W);
    localparam int TW   = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt;
    logic [AW:0]     wb_cnt;
    logic [AW:0]     wb_sum;
    logic [TW-1:0]   idle_cnt;
    logic            err_q;
    logic            timeout;
    logic            accept;
    logic            wb_live;

    logic [AW-1:0]   addr_a_q, addr_b_q, addr_c_q, addr_d_q, num_rows_q;
    logic [2:0]      vpu_mode_q;
    logic [W-1:0]    row_mask_q, col_mask_q;

    logic [UB_RD_LAT-1:0] a_vld_pipe, b_vld_pipe, sw_pipe;
    logic [IDXW-1:0]      idx_pipe [UB_RD_LAT];
    logic [IDXW-1:0]      idx_in;
    logic                 sw_in;

    assign accept  = cmd_valid && cmd_ready;
    assign wb_live = writeback_done && (state == S_STREAM || state == S_DRAIN);
    assign wb_sum  = wb_cnt + {{AW{1'b0}}, writeback_done};

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        case (state)
            S_IDLE:   if (cmd_valid) state_nxt = S_LOAD_W;
            S_LOAD_W: if (cnt == AW'(W - 1))
                          state_nxt = (num_rows_q != '0) ? S_STREAM : S_DONE;
            S_STREAM: if (cnt == num_rows_q - AW'(1)) state_nxt = S_DRAIN;
            S_DRAIN: begin
                // A pulse on the final cycle completes the drain without waiting a cycle.
                if (wb_sum >= {1'b0, num_rows_q}) begin
                    state_nxt = S_DONE;
                end else if (!writeback_done && (idle_cnt + TW'(1)) >= TW'(DRAIN_TIMEOUT)) begin
                    state_nxt = S_DONE;
                    timeout   = 1'b1;
                end
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            wb_cnt     <= '0;
            idle_cnt   <= '0;
            err_q      <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            addr_c_q   <= '0;
            addr_d_q   <= '0;
            num_rows_q <= '0;
            vpu_mode_q <= '0;
            row_mask_q <= '0;
            col_mask_q <= '0;
        end else begin
            state <= state_nxt;

            if (state != state_nxt)
                cnt <= '0;
            else if (state == S_LOAD_W || state == S_STREAM)
                cnt <= cnt + AW'(1);

            if (accept)
                wb_cnt <= '0;
            else if (wb_live)
                wb_cnt <= wb_cnt + (AW+1)'(1);

            // Counts cycles elapsed since the last pulse (or since DRAIN entry).
            if (state != S_DRAIN)
                idle_cnt <= '0;
            else if (writeback_done)
                idle_cnt <= TW'(1);
            else
                idle_cnt <= idle_cnt + TW'(1);

            if (accept)
                err_q <= 1'b0;
            else if (timeout)
                err_q <= 1'b1;

            if (accept) begin
                addr_a_q   <= cmd_addr_a;
                addr_b_q   <= cmd_addr_b;
                addr_c_q   <= cmd_addr_c;
                addr_d_q   <= cmd_addr_d;
                num_rows_q <= cmd_num_rows;
                vpu_mode_q <= cmd_vpu_mode;
                row_mask_q <= cmd_row_mask;
                col_mask_q <= cmd_col_mask;
            end
        end
    end

    assign idx_in = ctrl_rd_en_a ? cnt[IDXW-1:0] : '0;
    assign sw_in  = ctrl_rd_en_b && (cnt == '0);

    // Read-latency pipelines; not flushed on state changes so they drain naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_vld_pipe <= '0;
            b_vld_pipe <= '0;
            sw_pipe    <= '0;
            for (int i = 0; i < UB_RD_LAT; i++) idx_pipe[i] <= '0;
        end else begin
            a_vld_pipe[0] <= ctrl_rd_en_a;
            b_vld_pipe[0] <= ctrl_rd_en_b;
            sw_pipe[0]    <= sw_in;
            idx_pipe[0]   <= idx_in;
            for (int i = 1; i < UB_RD_LAT; i++) begin
                a_vld_pipe[i] <= a_vld_pipe[i-1];
                b_vld_pipe[i] <= b_vld_pipe[i-1];
                sw_pipe[i]    <= sw_pipe[i-1];
                idx_pipe[i]   <= idx_pipe[i-1];
            end
        end
    end

    assign cmd_ready         = (state == S_IDLE);
    assign busy              = (state != S_IDLE);
    assign done              = (state == S_DONE);
    assign err               = done && err_q;

    assign ctrl_rd_en_a      = (state == S_LOAD_W);
    assign ctrl_rd_addr_a    = ctrl_rd_en_a ? addr_a_q + cnt : '0;
    assign ctrl_accept_w     = a_vld_pipe[UB_RD_LAT-1];
    assign ctrl_weight_index = idx_pipe[UB_RD_LAT-1];

    assign ctrl_rd_en_b      = (state == S_STREAM);
    assign ctrl_rd_addr_b    = ctrl_rd_en_b ? addr_b_q + cnt : '0;
    assign ctrl_sys_valid    = b_vld_pipe[UB_RD_LAT-1];
    assign ctrl_sys_switch   = sw_pipe[UB_RD_LAT-1];

    assign ctrl_rd_en_c      = (state == S_STREAM || state == S_DRAIN);
    assign ctrl_rd_addr_c    = ctrl_rd_en_c ? addr_c_q : '0;

    assign ctrl_wr_addr_d    = addr_d_q + wb_cnt[AW-1:0];

    assign ctrl_vpu_mode     = busy ? vpu_mode_q : '0;
    assign ctrl_row_mask     = busy ? row_mask_q : '0;
    assign ctrl_col_mask     = busy ? col_mask_q : '0;
endmodule

// File: tb/tb_tpu_ctrl_seq.sv
// Directed bench for tpu_ctrl_seq with W=16, UB_RD_LAT=1, DRAIN_TIMEOUT=8.
// Cycle 0 of each command is the acceptance cycle; outputs sampled on the falling edge.
module tb_tpu_ctrl_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_addr_a, cmd_addr_b, cmd_addr_c, cmd_addr_d, cmd_num_rows;
    logic [2:0]  cmd_vpu_mode;
    logic [15:0] cmd_row_mask, cmd_col_mask;
    logic [9:0]  ctrl_rd_addr_a, ctrl_rd_addr_b, ctrl_rd_addr_c, ctrl_wr_addr_d;
    logic        ctrl_rd_en_a, ctrl_accept_w, ctrl_rd_en_b, ctrl_sys_valid, ctrl_sys_switch, ctrl_rd_en_c;
    logic [3:0]  ctrl_weight_index;
    logic [2:0]  ctrl_vpu_mode;
    logic [15:0] ctrl_row_mask, ctrl_col_mask;
    logic        writeback_done, busy, done, err;

    tpu_ctrl_seq #(
        .SYSTOLIC_ARRAY_WIDTH(16), .ADDR_WIDTH(10), .UB_RD_LAT(1), .DRAIN_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_c(cmd_addr_c),
        .cmd_addr_d(cmd_addr_d), .cmd_num_rows(cmd_num_rows), .cmd_vpu_mode(cmd_vpu_mode),
        .cmd_row_mask(cmd_row_mask), .cmd_col_mask(cmd_col_mask),
        .ctrl_rd_addr_a(ctrl_rd_addr_a), .ctrl_rd_en_a(ctrl_rd_en_a),
        .ctrl_accept_w(ctrl_accept_w), .ctrl_weight_index(ctrl_weight_index),
        .ctrl_rd_addr_b(ctrl_rd_addr_b), .ctrl_rd_en_b(ctrl_rd_en_b),
        .ctrl_sys_valid(ctrl_sys_valid), .ctrl_sys_switch(ctrl_sys_switch),
        .ctrl_rd_addr_c(ctrl_rd_addr_c), .ctrl_rd_en_c(ctrl_rd_en_c),
        .ctrl_vpu_mode(ctrl_vpu_mode), .ctrl_wr_addr_d(ctrl_wr_addr_d),
        .ctrl_row_mask(ctrl_row_mask), .ctrl_col_mask(ctrl_col_mask),
        .writeback_done(writeback_done), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  a, b, c, d, n;
        logic [2:0]  mode;
        logic [15:0] rm, cm;
        int          np;        // writeback pulses issued in DRAIN, every other cycle
        int          done_cyc;  // hand-computed cycle of the done pulse
        logic        err;
        logic [9:0]  wr_final;  // hand-computed ctrl_wr_addr_d on the done cycle
    } vec_t;

    vec_t vecs [5];
    int   n_vec = 0;
    int   n_err = 0;
    int   cur_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cur_cyc, act, exp);
        end
    endtask

    function automatic logic [9:0] wrap(input logic [9:0] base, input int off);
        logic [31:0] o;
        o = off;
        return base + o[9:0];
    endfunction

    task automatic run_vec(input vec_t v);
        int nn, ds, wb, last;
        bit pulse, e;
        nn = int'(v.n);
        ds = 17 + nn;
        wb = 0;
        @(negedge clk);
        for (int c = 0; c <= v.done_cyc + 1; c++) begin
            cur_cyc = c;
            chk("cmd_ready", cmd_ready, (c == 0 || c == v.done_cyc + 1));
            chk("busy", busy, (c >= 1 && c <= v.done_cyc));
            e = (c >= 1 && c <= 16);
            chk("rd_en_a", ctrl_rd_en_a, e);
            if (e) chk("rd_addr_a", ctrl_rd_addr_a, wrap(v.a, c - 1));
            e = (c >= 2 && c <= 17);
            chk("accept_w", ctrl_accept_w, e);
            if (e) chk("weight_index", ctrl_weight_index, c - 2);
            e = (nn > 0 && c >= 17 && c <= 16 + nn);
            chk("rd_en_b", ctrl_rd_en_b, e);
            if (e) chk("rd_addr_b", ctrl_rd_addr_b, wrap(v.b, c - 17));
            chk("sys_valid", ctrl_sys_valid, (nn > 0 && c >= 18 && c <= 17 + nn));
            chk("sys_switch", ctrl_sys_switch, (nn > 0 && c == 18));
            e = (nn > 0 && c >= 17 && c < v.done_cyc);
            chk("rd_en_c", ctrl_rd_en_c, e);
            if (e) chk("rd_addr_c", ctrl_rd_addr_c, v.c);
            if (c >= 1 && c <= v.done_cyc) chk("wr_addr_d", ctrl_wr_addr_d, wrap(v.d, wb));
            if (c == v.done_cyc) chk("wr_addr_final", ctrl_wr_addr_d, v.wr_final);
            chk("done", done, (c == v.done_cyc));
            chk("err", err, (c == v.done_cyc) ? v.err : 1'b0);
            e = (c >= 1 && c <= v.done_cyc);
            chk("vpu_mode", ctrl_vpu_mode, e ? v.mode : 3'd0);
            chk("row_mask", ctrl_row_mask, e ? v.rm : 16'd0);
            chk("col_mask", ctrl_col_mask, e ? v.cm : 16'd0);

            // Drive the inputs for this cycle; cmd_valid also held during DONE, where it must be refused.
            cmd_valid    = (c == 0 || c == v.done_cyc);
            cmd_addr_a   = v.a;  cmd_addr_b = v.b;  cmd_addr_c = v.c;  cmd_addr_d = v.d;
            cmd_num_rows = v.n;  cmd_vpu_mode = v.mode;
            cmd_row_mask = v.rm; cmd_col_mask = v.cm;
            last  = c - ds - 1;
            pulse = (nn > 0 && last >= 0 && (last % 2) == 0 && (last / 2) < v.np);
            writeback_done = pulse || (c == 5);   // the cycle-5 pulse lands in LOAD_W and must be ignored
            @(negedge clk);
            if (pulse) wb++;
        end
        cmd_valid      = 1'b0;
        writeback_done = 1'b0;
    endtask

    initial begin
        //          a       b       c       d       n      mode  rm         cm         np done err wr_final
        vecs[0] = '{10'h010, 10'h040, 10'h022, 10'h080, 10'd4, 3'd3, 16'hA5A5, 16'h0FF0, 4, 29, 1'b0, 10'h084};
        vecs[1] = '{10'h100, 10'h200, 10'h005, 10'h030, 10'd0, 3'd1, 16'hFFFF, 16'h0001, 0, 17, 1'b0, 10'h030};
        vecs[2] = '{10'h3F8, 10'h3FF, 10'h3FE, 10'h3FF, 10'd2, 3'd5, 16'h8001, 16'h7FFE, 2, 23, 1'b0, 10'h001};
        vecs[3] = '{10'h000, 10'h060, 10'h070, 10'h090, 10'd3, 3'd7, 16'h1234, 16'h4321, 2, 31, 1'b1, 10'h092};
        vecs[4] = '{10'h2A0, 10'h155, 10'h0AA, 10'h3F0, 10'd1, 3'd2, 16'h00FF, 16'hFF00, 1, 20, 1'b0, 10'h3F1};

        rst = 1'b0; cmd_valid = 1'b0; writeback_done = 1'b0;
        cmd_addr_a = '0; cmd_addr_b = '0; cmd_addr_c = '0; cmd_addr_d = '0;
        cmd_num_rows = '0; cmd_vpu_mode = '0; cmd_row_mask = '0; cmd_col_mask = '0;
        repeat (3) @(negedge clk);
        cur_cyc = -1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_en", {ctrl_rd_en_a, ctrl_rd_en_b, ctrl_rd_en_c, ctrl_accept_w, ctrl_sys_valid, ctrl_sys_switch}, 0);
        chk("rst_addrs", {ctrl_rd_addr_a, ctrl_rd_addr_b, ctrl_rd_addr_c}, 0);
        chk("rst_wr_addr_d", ctrl_wr_addr_d, 0);
        chk("rst_masks", {ctrl_row_mask, ctrl_col_mask}, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset asserted mid-STREAM: immediate abort, no done pulse, then a clean rerun.
        @(negedge clk);
        cmd_addr_a = 10'h010; cmd_addr_b = 10'h040; cmd_addr_c = 10'h022; cmd_addr_d = 10'h080;
        cmd_num_rows = 10'd4; cmd_vpu_mode = 3'd3; cmd_row_mask = 16'hA5A5; cmd_col_mask = 16'h0FF0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (17) @(negedge clk);
        cur_cyc = 18;
        chk("mid_rd_en_b", ctrl_rd_en_b, 1);
        chk("mid_sys_valid", ctrl_sys_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
        chk("arst_rd_en_b", ctrl_rd_en_b, 0);
        chk("arst_rd_addr_b", ctrl_rd_addr_b, 0);
        chk("arst_sys_valid", ctrl_sys_valid, 0);
        chk("arst_rd_en_c", ctrl_rd_en_c, 0);
        chk("arst_vpu_mode", ctrl_vpu_mode, 0);
        chk("arst_wr_addr_d", ctrl_wr_addr_d, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        begin
            int seen_done;
            seen_done = 0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (done) seen_done++;
            end
            cur_cyc = -2;
            chk("post_rst_no_done", seen_done, 0);
            chk("post_rst_cmd_ready", cmd_ready, 1);
        end
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
